html_char_stream: RTL and testbench
===================================

HTML_CHAR_STREAM -- requirements
Module: html_char_stream

Interface
REQ-001 The block SHALL have parameter CHAR_W, default 8: character width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16: byte-address and length width.
REQ-003 The block SHALL have parameter DEPTH, default 8: output FIFO entries, a power of two, at least 2.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port state_enable, input, 1 bit: asynchronous active-low reset (0 = reset, 1 = run).
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a stream; honoured only in IDLE or DONE.
REQ-007 The block SHALL have port base_addr, input, ADDR_W bits: first source address; sampled on start.
REQ-008 The block SHALL have port length, input, ADDR_W bits: maximum characters to read; sampled on start.
REQ-009 The block SHALL have port mem_req, output, 1 bit: read request to the source memory.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W bits: read address, valid while mem_req is high.
REQ-011 The block SHALL have ports mem_rvalid (input, 1 bit) and mem_rdata (input, CHAR_W bits): read-return strobe and data.
REQ-012 The block SHALL have port char_out, output, CHAR_W bits: FIFO head character.
REQ-013 The block SHALL have ports char_valid (output, 1 bit) and char_ready (input, 1 bit): consumer handshake; a transfer occurs when both are high.
REQ-014 The block SHALL have port has_finished, output, 1 bit: high in DONE.
REQ-015 The block SHALL have port busy, output, 1 bit: high in FETCH or DRAIN.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE; start moves IDLE or DONE to FETCH, flushes the FIFO and loads addr=base_addr, remaining=length.
REQ-017 In FETCH, mem_req SHALL be high (one cycle per request) only when no request is outstanding, remaining>0 and FIFO count plus outstanding is less than DEPTH.
REQ-018 At most one request SHALL be outstanding; mem_rvalid SHALL arrive 1 or more cycles after the request, and an mem_rvalid with nothing outstanding SHALL be ignored.
REQ-019 Each accepted request SHALL increment addr modulo 2^ADDR_W (wrap-around permitted) and decrement remaining.
REQ-020 A returned non-zero character SHALL be pushed into the FIFO on the mem_rvalid cycle.
REQ-021 A returned zero character is a terminator: it SHALL NOT be pushed, remaining SHALL be cleared and the FSM SHALL go to DRAIN.
REQ-022 FETCH SHALL go to DRAIN when remaining reaches 0 and nothing is outstanding.
REQ-023 DRAIN SHALL go to DONE in the cycle after the FIFO becomes empty.
REQ-024 A start with length=0 SHALL go FETCH to DRAIN to DONE with no mem_req.
REQ-025 char_valid SHALL equal FIFO not-empty, and char_out SHALL be stable while char_valid is high and char_ready is low.
REQ-026 A simultaneous push and pop SHALL be legal at any count, including full and empty-with-bypass-disabled (a push to an empty FIFO is visible the next cycle).
REQ-027 Latency SHALL be fixed: a character returned on cycle N appears on char_out at cycle N+1.
REQ-028 start while busy SHALL be ignored.
REQ-029 DONE SHALL hold has_finished=1 until start or reset.

Reset
REQ-030 On state_enable=0 the block SHALL asynchronously enter IDLE and drive mem_req=0, mem_addr=0, char_out=0, char_valid=0, has_finished=0, busy=0, FIFO empty, nothing outstanding.
REQ-031 On reset during FETCH, a late mem_rvalid after reset release SHALL be ignored.
REQ-032 Reset release SHALL be synchronised externally; no start SHALL be honoured in the release cycle.

Configuration
REQ-033 With HTML_PEEK_EN defined, outputs peek_char (CHAR_W bits) and peek_valid (1 bit) SHALL exist, presenting the FIFO entry after the head (peek_valid = count at least 2) for tokenizer two-character lookahead such as "</" or "<!".
REQ-034 Without HTML_PEEK_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 A shared package html_pkg SHALL hold the FSM state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3) and the character-width constant used by CHAR_BITES users.
REQ-036 The FIFO SHALL be the sub-module html_char_fifo (parameters CHAR_W and DEPTH; push, pop, full, empty, count, head and next outputs).

Verification
REQ-037 Scenario: base=0x0010, length=5, memory "<html", ready=1 -> chars 0x3C,0x68,0x74,0x6D,0x6C in order, then has_finished=1, exactly 5 mem_req.
REQ-038 Scenario: length=10, data "ab\0xyz" -> only 0x61,0x62 delivered, 3 requests issued, then DONE.
REQ-039 Scenario: DEPTH=8, char_ready=0, length=20 -> mem_req stops after 8 fills, char_out unchanged; release ready -> remaining 12 chars delivered with no loss or duplicate.
REQ-040 Scenario: base=0xFFFE, length=4 -> mem_addr sequence FFFE, FFFF, 0000, 0001.
REQ-041 Scenario: state_enable=0 mid-FETCH with a request outstanding -> all outputs at reset values immediately; a stray mem_rvalid after release pushes nothing.
REQ-042 Scenario: with HTML_PEEK_EN, "</p" -> head 0x3C with peek 0x2F, peek_valid=1; with a single char left, peek_valid=0.

Source files
------------

// File: rtl/html_pkg.sv
// html_pkg: definitions shared by the HTML character streamer.
//   CHAR_BITS : default character width used by the streamer, its FIFO and its interface
//   state_e   : controller state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
package html_pkg;

    localparam int CHAR_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/html_char_stream_if.sv
// html_char_stream_if: source-memory read bus and character output stream.
//   mem_req/mem_addr       : read request and address (streamer -> memory)
//   mem_rvalid/mem_rdata   : read-return strobe and data (memory -> streamer)
//   char_out/char_valid    : FIFO head and its valid flag (streamer -> consumer)
//   char_ready             : consumer accepts char_out when high with char_valid
//   peek_char/peek_valid   : entry after the head; only when HTML_PEEK_EN is defined
// master = streamer side, slave = memory/consumer side.
interface html_char_stream_if import html_pkg::*; #(
    parameter int CHAR_W = CHAR_BITS,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [CHAR_W-1:0] mem_rdata;
    logic [CHAR_W-1:0] char_out;
    logic              char_valid;
    logic              char_ready;
`ifdef HTML_PEEK_EN
    logic [CHAR_W-1:0] peek_char;
    logic              peek_valid;
`endif

    modport master (
        output mem_req, mem_addr, char_out, char_valid,
`ifdef HTML_PEEK_EN
        output peek_char, peek_valid,
`endif
        input  mem_rvalid, mem_rdata, char_ready
    );

    modport slave (
        input  mem_req, mem_addr, char_out, char_valid,
`ifdef HTML_PEEK_EN
        input  peek_char, peek_valid,
`endif
        output mem_rvalid, mem_rdata, char_ready
    );

endinterface

// File: rtl/html_char_fifo.sv
// html_char_fifo: DEPTH-entry character FIFO without bypass (a push into an
// empty FIFO becomes visible on the following cycle).
//   clock, state_enable : clock and asynchronous active-low reset
//   flush               : empties the FIFO (pointers and count only)
//   push, push_data     : write request and data
//   pop                 : read request (ignored when empty)
//   full, empty, count  : occupancy status
//   head                : oldest entry, forced to zero while empty
//   next                : entry after the head, zero unless count >= 2
//                         (port present only when HTML_PEEK_EN is defined)
module html_char_fifo import html_pkg::*; #(
    parameter int CHAR_W = CHAR_BITS,
    parameter int DEPTH  = 8
) (
    input  logic                   clock,
    input  logic                   state_enable,
    input  logic                   flush,
    input  logic                   push,
    input  logic [CHAR_W-1:0]      push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [CHAR_W-1:0]      head
`ifdef HTML_PEEK_EN
    ,
    output logic [CHAR_W-1:0]      next
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // A push while full is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only; validity comes from the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

`ifdef HTML_PEEK_EN
    assign next = (count_q >= CNT_W'(2)) ? mem_q[rd_ptr_q + PTR_W'(1)] : '0;
`endif

endmodule

// File: rtl/html_char_stream.sv
// html_char_stream: reads a zero-terminated or length-bounded character string
// from a source memory and streams it to a consumer through a small FIFO.
//   clock        : single clock, rising edge
//   state_enable : asynchronous active-low reset (release synchronised externally)
//   start        : one-cycle pulse, honoured only in IDLE or DONE
//   base_addr    : first source address, sampled on start
//   length       : maximum characters to read, sampled on start
//   has_finished : high in DONE
//   busy         : high in FETCH or DRAIN
//   bus          : memory read bus and character stream (html_char_stream_if.master)
// Defining HTML_PEEK_EN adds bus.peek_char/bus.peek_valid for two-character lookahead.
module html_char_stream import html_pkg::*; #(
    parameter int CHAR_W = CHAR_BITS,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clock,
    input  logic              state_enable,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              has_finished,
    output logic              busy,
    html_char_stream_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              outstanding_q, outstanding_d;

    logic              mem_req;
    logic              flush;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CHAR_W-1:0] head;
    logic              rvalid_acc;
    logic              room;

    // Read data is only meaningful against our own outstanding request;
    // stray strobes (e.g. a late return after reset) are dropped here.
    assign rvalid_acc = outstanding_q && bus.mem_rvalid;

    // Space is reserved for an in-flight read so a return can always be pushed.
    assign room = !full && ((count + CNT_W'(outstanding_q)) < CNT_W'(DEPTH));

    assign pop = !empty && bus.char_ready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        mem_req       = 1'b0;
        flush         = 1'b0;
        push          = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = FETCH;
                    flush         = 1'b1;
                    addr_d        = base_addr;
                    remaining_d   = length;
                    outstanding_d = 1'b0;
                end
            end
            FETCH: begin
                if (rvalid_acc) begin
                    outstanding_d = 1'b0;
                    if (bus.mem_rdata == '0) begin
                        // Terminator: nothing more is read, whatever length allowed.
                        remaining_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        push = 1'b1;
                    end
                end else if (!outstanding_q && (remaining_q == '0)) begin
                    state_d = DRAIN;
                end else if (!outstanding_q && room) begin
                    mem_req       = 1'b1;
                    outstanding_d = 1'b1;
                    addr_d        = addr_q + ADDR_W'(1);
                    remaining_d   = remaining_q - ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef HTML_PEEK_EN
    logic [CHAR_W-1:0] next_char;
`endif

    html_char_fifo #(
        .CHAR_W (CHAR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .state_enable (state_enable),
        .flush        (flush),
        .push         (push),
        .push_data    (bus.mem_rdata),
        .pop          (pop),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .head         (head)
`ifdef HTML_PEEK_EN
        ,
        .next         (next_char)
`endif
    );

    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = addr_q;
    assign bus.char_out   = head;
    assign bus.char_valid = !empty;
    assign has_finished   = (state_q == DONE);
    assign busy           = (state_q == FETCH) || (state_q == DRAIN);

`ifdef HTML_PEEK_EN
    assign bus.peek_char  = next_char;
    assign bus.peek_valid = (count >= CNT_W'(2));
`endif

endmodule

// File: tb/tb_html_char_stream.sv
// tb_html_char_stream: directed bench for html_char_stream with a one-cycle
// memory model, a character scoreboard and an expected-address queue.
module tb_html_char_stream;

    logic        clock;
    logic        state_enable;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        has_finished;
    logic        busy;

    html_char_stream_if #(.CHAR_W(8), .ADDR_W(16)) bus ();

    html_char_stream #(.CHAR_W(8), .ADDR_W(16), .DEPTH(8)) dut (
        .clock        (clock),
        .state_enable (state_enable),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .has_finished (has_finished),
        .busy         (busy),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks;
    int          errors;
    int          req_count;
    int          r0;
    logic [7:0]  mem_model [65536];
    logic [7:0]  exp_q [$];
    logic [15:0] addr_exp [$];
    bit          pend;
    bit          mem_hold;
    logic [15:0] paddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes as the coming edge will see them,
    // then at the falling edge score transfers and answer memory requests.
    task automatic tick();
        bit          xfer;
        bit          rq;
        logic [7:0]  xd;
        logic [15:0] ra;
        logic [7:0]  ec;
        xfer = bus.char_valid && bus.char_ready;
        xd   = bus.char_out;
        rq   = bus.mem_req;
        ra   = bus.mem_addr;
        @(negedge clock);
        if (xfer) begin
            chk("char_extra", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                ec = exp_q.pop_front();
                chk("char", xd, ec);
            end
        end
        if (rq) begin
            req_count++;
            if (addr_exp.size() > 0) chk("mem_addr", ra, addr_exp.pop_front());
            pend  = 1'b1;
            paddr = ra;
        end
        if (pend && !mem_hold) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_model[paddr];
            pend           = 1'b0;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 8'h00;
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!has_finished && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", has_finished, 1);
    endtask

    task automatic load(input logic [15:0] a, input string s);
        for (int i = 0; i < s.len(); i++) mem_model[16'(a + 16'(i))] = s[i];
    endtask

    initial begin
        checks = 0; errors = 0; req_count = 0;
        pend = 1'b0; mem_hold = 1'b0; paddr = '0;
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'h00;
        state_enable   = 1'b0;
        start          = 1'b0;
        base_addr      = '0;
        length         = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.char_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_char_out", bus.char_out, 0);
        chk("rst_char_valid", bus.char_valid, 0);
        chk("rst_has_finished", has_finished, 0);
        chk("rst_busy", busy, 0);
        state_enable = 1'b1;
        tick(); tick();

        // "<html" at 0x0010, with the one-cycle return-to-output latency
        load(16'h0010, "<html");
        foreach (exp_q[i]) ;
        exp_q.push_back(8'h3C); exp_q.push_back(8'h68); exp_q.push_back(8'h74);
        exp_q.push_back(8'h6D); exp_q.push_back(8'h6C);
        r0 = req_count;
        do_start(16'h0010, 16'd5);
        chk("s1_busy", busy, 1);
        tick();
        chk("s1_valid_before", bus.char_valid, 0);
        tick();
        chk("s1_valid_latency", bus.char_valid, 1);
        chk("s1_head", bus.char_out, 8'h3C);
        wait_done(200);
        chk("s1_reqs", req_count - r0, 5);
        chk("s1_sb_empty", exp_q.size(), 0);
        chk("s1_valid_end", bus.char_valid, 0);
        repeat (5) tick();
        chk("s1_finished_hold", has_finished, 1);
        chk("s1_busy_done", busy, 0);

        // Terminator inside the length window
        load(16'h0100, "ab");
        mem_model[16'h0102] = 8'h00;
        load(16'h0103, "xyz");
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        r0 = req_count;
        do_start(16'h0100, 16'd10);
        wait_done(200);
        chk("s2_reqs", req_count - r0, 3);
        chk("s2_sb_empty", exp_q.size(), 0);

        // Back-pressure: FIFO fills to 8, a start while busy is ignored
        for (int i = 0; i < 20; i++) begin
            mem_model[16'h0200 + 16'(i)] = 8'h41 + 8'(i);
            exp_q.push_back(8'h41 + 8'(i));
        end
        load(16'h0300, "zzz");
        bus.char_ready = 1'b0;
        r0 = req_count;
        do_start(16'h0200, 16'd20);
        repeat (40) tick();
        chk("s3_reqs_stall", req_count - r0, 8);
        chk("s3_mem_req_low", bus.mem_req, 0);
        chk("s3_head", bus.char_out, 8'h41);
        do_start(16'h0300, 16'd3);
        repeat (10) tick();
        chk("s3_busy_ignore", busy, 1);
        chk("s3_reqs_ignore", req_count - r0, 8);
        chk("s3_head_stable", bus.char_out, 8'h41);
        for (int i = 0; i < 400 && !has_finished; i++) begin
            bus.char_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.char_ready = 1'b1;
        wait_done(60);
        chk("s3_reqs_total", req_count - r0, 20);
        chk("s3_sb_empty", exp_q.size(), 0);

        // Address wrap-around
        load(16'hFFFE, "wx");
        load(16'h0000, "yz");
        addr_exp.push_back(16'hFFFE); addr_exp.push_back(16'hFFFF);
        addr_exp.push_back(16'h0000); addr_exp.push_back(16'h0001);
        exp_q.push_back(8'h77); exp_q.push_back(8'h78);
        exp_q.push_back(8'h79); exp_q.push_back(8'h7A);
        r0 = req_count;
        do_start(16'hFFFE, 16'd4);
        wait_done(200);
        chk("s4_reqs", req_count - r0, 4);
        chk("s4_addr_all_seen", addr_exp.size(), 0);
        chk("s4_sb_empty", exp_q.size(), 0);

        // Zero length
        r0 = req_count;
        do_start(16'h0000, 16'd0);
        chk("s5_busy", busy, 1);
        wait_done(10);
        chk("s5_reqs", req_count - r0, 0);

        // Reset with a request outstanding, then a stray return
        load(16'h0400, "QRST");
        bus.char_ready = 1'b0;
        do_start(16'h0400, 16'd4);
        tick(); tick();
        mem_hold = 1'b1;
        tick();
        chk("s6_pre_valid", bus.char_valid, 1);
        chk("s6_pre_head", bus.char_out, 8'h51);
        chk("s6_pre_pend", pend, 1);
        state_enable = 1'b0;
        #1;
        chk("s6_rst_mem_req", bus.mem_req, 0);
        chk("s6_rst_mem_addr", bus.mem_addr, 0);
        chk("s6_rst_char_out", bus.char_out, 0);
        chk("s6_rst_char_valid", bus.char_valid, 0);
        chk("s6_rst_has_finished", has_finished, 0);
        chk("s6_rst_busy", busy, 0);
        tick(); tick();
        state_enable = 1'b1;
        tick();
        mem_hold = 1'b0;
        tick();
        chk("s6_stray_driven", bus.mem_rvalid, 1);
        tick(); tick();
        chk("s6_stray_valid", bus.char_valid, 0);
        chk("s6_stray_busy", busy, 0);
        chk("s6_stray_finished", has_finished, 0);
        bus.char_ready = 1'b1;

`ifdef HTML_PEEK_EN
        // Two-character lookahead
        load(16'h0500, "</p");
        bus.char_ready = 1'b0;
        do_start(16'h0500, 16'd3);
        repeat (10) tick();
        chk("s7_head", bus.char_out, 8'h3C);
        chk("s7_peek", bus.peek_char, 8'h2F);
        chk("s7_peek_valid", bus.peek_valid, 1);
        exp_q.push_back(8'h3C); exp_q.push_back(8'h2F);
        bus.char_ready = 1'b1;
        tick(); tick();
        bus.char_ready = 1'b0;
        tick();
        chk("s7_last_head", bus.char_out, 8'h70);
        chk("s7_last_peek_valid", bus.peek_valid, 0);
        exp_q.push_back(8'h70);
        bus.char_ready = 1'b1;
        wait_done(50);
`endif

        chk("final_sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
